// File: rtl/hazard_glitch_monitor_if.sv
// Observation bus between the static-hazard monitor and whatever drives/reads it.
// The last_ts member exists only when GLITCH_TIMESTAMP_EN is defined.
interface hazard_glitch_monitor_if #(
    parameter int MAX_GLITCH = 4,
    parameter int CNT_W      = 8
);
    localparam int W_W = $clog2(MAX_GLITCH + 1);

    logic             sig_in;
    logic             clr;
    logic             level;
    logic             glitch_pulse;
    logic             glitch_type;
    logic [W_W-1:0]   last_width;
    logic [CNT_W-1:0] g0_cnt;
    logic [CNT_W-1:0] g1_cnt;
    logic             hazard_flag;
`ifdef GLITCH_TIMESTAMP_EN
    logic [15:0]      last_ts;
`endif

`ifdef GLITCH_TIMESTAMP_EN
    modport master (
        output sig_in, clr,
        input  level, glitch_pulse, glitch_type, last_width,
               g0_cnt, g1_cnt, hazard_flag, last_ts
    );
    modport slave (
        input  sig_in, clr,
        output level, glitch_pulse, glitch_type, last_width,
               g0_cnt, g1_cnt, hazard_flag, last_ts
    );
`else
    modport master (
        output sig_in, clr,
        input  level, glitch_pulse, glitch_type, last_width,
               g0_cnt, g1_cnt, hazard_flag
    );
    modport slave (
        input  sig_in, clr,
        output level, glitch_pulse, glitch_type, last_width,
               g0_cnt, g1_cnt, hazard_flag
    );
`endif
endinterface

// File: rtl/hazard_glitch_monitor.sv
// Oversampling static-hazard observer: classifies short excursions as static-0/static-1 glitches.
// Optional GLITCH_TIMESTAMP_EN adds a free-running 16-bit timestamp captured into last_ts.
module hazard_glitch_monitor #(
    parameter int   MAX_GLITCH = 4,
    parameter int   CNT_W      = 8,
    parameter logic RST_LVL    = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hazard_glitch_monitor_if.slave  mon
);
    localparam int             W_W         = $clog2(MAX_GLITCH + 1);
    localparam int             SYNC_STAGES = 2;
    localparam logic [W_W-1:0] MAX_W       = W_W'(MAX_GLITCH);
    localparam logic [W_W-1:0] ONE_W       = W_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        ST_STABLE    = 1'b0,
        ST_EXCURSION = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = mon.sig_in;
            end else begin : g_chain
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_LVL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Excursion tracking FSM
    // ------------------------------------------------------------------
    state_t         state_q;
    state_t         state_d;
    logic [W_W-1:0] width_q;
    logic [W_W-1:0] width_d;
    logic           level_q;
    logic           level_d;
    logic           detect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            width_q <= '0;
            level_q <= RST_LVL;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        width_d = width_q;
        level_d = level_q;
        detect  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (s != level_q) begin
                    state_d = ST_EXCURSION;
                    width_d = ONE_W;
                end
            end
            ST_EXCURSION: begin
                if (s == level_q) begin
                    // Returned to the prior level in time: this was a hazard, not an edge.
                    detect  = 1'b1;
                    state_d = ST_STABLE;
                    width_d = '0;
                end else if (width_q == MAX_W) begin
                    level_d = ~level_q;
                    state_d = ST_STABLE;
                    width_d = '0;
                end else begin
                    width_d = width_q + ONE_W;
                end
            end
            default: begin
                state_d = ST_STABLE;
                width_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Report registers: clr overrides a simultaneous detect, except the strobe
    // ------------------------------------------------------------------
    logic           glitch_pulse_q;
    logic           glitch_pulse_d;
    logic           glitch_type_q;
    logic           glitch_type_d;
    logic [W_W-1:0] last_width_q;
    logic [W_W-1:0] last_width_d;
    logic           hazard_flag_q;
    logic           hazard_flag_d;

    always_comb begin
        glitch_pulse_d = detect;
        glitch_type_d  = glitch_type_q;
        last_width_d   = last_width_q;
        hazard_flag_d  = hazard_flag_q;
        if (mon.clr) begin
            glitch_type_d = 1'b0;
            last_width_d  = '0;
            hazard_flag_d = 1'b0;
        end else if (detect) begin
            glitch_type_d = level_q;
            last_width_d  = width_q;
            hazard_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_pulse_q <= 1'b0;
            glitch_type_q  <= 1'b0;
            last_width_q   <= '0;
            hazard_flag_q  <= 1'b0;
        end else begin
            glitch_pulse_q <= glitch_pulse_d;
            glitch_type_q  <= glitch_type_d;
            last_width_q   <= last_width_d;
            hazard_flag_q  <= hazard_flag_d;
        end
    end

    // ------------------------------------------------------------------
    // Saturating per-type counters: index 0 = static-0, index 1 = static-1
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (mon.clr) begin
                    cnt_d = '0;
                end else if (detect && (level_q == 1'(gi)) && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

`ifdef GLITCH_TIMESTAMP_EN
    // ------------------------------------------------------------------
    // Timestamp: last_ts holds the ts value present on the detect edge
    // ------------------------------------------------------------------
    logic [15:0] ts_q;
    logic [15:0] ts_d;
    logic [15:0] last_ts_q;
    logic [15:0] last_ts_d;

    always_comb begin
        ts_d      = ts_q + 16'd1;
        last_ts_d = last_ts_q;
        if (mon.clr) begin
            last_ts_d = '0;
        end else if (detect) begin
            last_ts_d = ts_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q      <= '0;
            last_ts_q <= '0;
        end else begin
            ts_q      <= ts_d;
            last_ts_q <= last_ts_d;
        end
    end

    assign mon.last_ts = last_ts_q;
`endif

    assign mon.level        = level_q;
    assign mon.glitch_pulse = glitch_pulse_q;
    assign mon.glitch_type  = glitch_type_q;
    assign mon.last_width   = last_width_q;
    assign mon.g0_cnt       = g_cnt[0].cnt_q;
    assign mon.g1_cnt       = g_cnt[1].cnt_q;
    assign mon.hazard_flag  = hazard_flag_q;

endmodule
